// File: rtl/ads_rx_pkg.sv
// Shared types and helpers for the multi-lane ADS serial receiver.
package ads_rx_pkg;

  localparam int unsigned DW_MAX = 32;
  localparam int unsigned SKIP_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    SKIPPING = 2'd2
  } cap_state_t;

  typedef logic signed [DW_MAX-1:0] lane_word_t;

  // Increment v, holding at 2^w-1 (w up to 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v == max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ads_rx_if.sv
// Valid/ready stream carrying one packed word per frame (lane i at [i*DW +: DW]).
interface ads_rx_if #(
  parameter int unsigned DW  = 24,
  parameter int unsigned NCH = 4
);
  logic [NCH*DW-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/ads_rx_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only when a pop frees the head slot.
module ads_rx_fifo #(
  parameter int unsigned W     = 96,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     sclk,
  input  logic                     areset_n,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          wr_en;
  logic          rd_en;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign level   = cnt;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge sclk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge sclk) begin
    if (!areset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ads_multi_rx.sv
// NCH-lane ADS1675-style frame receiver: drdy edge detect, lock-frame skipping,
// truncation detection and a buffered valid/ready output.
module ads_multi_rx
  import ads_rx_pkg::*;
#(
  parameter int unsigned DW    = 24,
  parameter int unsigned NCH   = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SKIP  = 1,
  parameter int unsigned CW    = 16
) (
  input  logic                   sclk,
  input  logic                   areset_n,
  input  logic                   en,
  input  logic                   drdy,
  input  logic [NCH-1:0]         dout,
  ads_rx_if.master               m,
  output logic [$clog2(DEPTH):0] level,
  output logic [CW-1:0]          frame_err_cnt,
  output logic [CW-1:0]          drop_cnt
);
  localparam int unsigned       BCW       = $clog2(DW);
  localparam logic [BCW-1:0]    LAST_BIT  = BCW'(DW - 1);
  localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(SKIP);

  cap_state_t          state_p0, state_nx;
  logic [BCW-1:0]      bit_cnt_p0, bit_nx;
  logic [SKIP_W-1:0]   skip_cnt_p0, skip_nx, skip_left;
  logic                drdy_p0;
  logic                start, last, push, trunc, pop, full, empty, drop;
  logic signed [DW-1:0] sr_p0 [NCH];
  logic [NCH*DW-1:0]   frame;
  logic [NCH*DW-1:0]   head;

  assign start = drdy && !drdy_p0;
  assign last  = (bit_cnt_p0 == LAST_BIT);

  always_comb begin
    state_nx  = state_p0;
    bit_nx    = bit_cnt_p0;
    skip_nx   = skip_cnt_p0;
    skip_left = skip_cnt_p0;
    push      = 1'b0;
    trunc     = 1'b0;
    if (!en) begin
      state_nx = IDLE;
      bit_nx   = '0;
      skip_nx  = SKIP_INIT;
    end else begin
      case (state_p0)
        IDLE: begin
          if (start) begin
            state_nx = (skip_cnt_p0 != '0) ? SKIPPING : SHIFT;
            bit_nx   = '0;
          end
        end
        SHIFT, SKIPPING: begin
          if (last) begin
            // A start on this edge is a back-to-back frame, chosen with the updated skip count.
            if (state_p0 == SHIFT) push = 1'b1;
            else                   skip_left = skip_cnt_p0 - SKIP_W'(1);
            skip_nx  = skip_left;
            state_nx = start ? ((skip_left != '0) ? SKIPPING : SHIFT) : IDLE;
            bit_nx   = '0;
          end else if (start) begin
            trunc    = 1'b1;
            state_nx = (skip_cnt_p0 != '0) ? SKIPPING : SHIFT;
            bit_nx   = '0;
          end else begin
            bit_nx = bit_cnt_p0 + BCW'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Stage p0: capture registers
  always_ff @(posedge sclk) begin
    if (!areset_n) begin
      state_p0    <= IDLE;
      bit_cnt_p0  <= '0;
      skip_cnt_p0 <= SKIP_INIT;
      drdy_p0     <= 1'b1;
    end else begin
      state_p0    <= state_nx;
      bit_cnt_p0  <= bit_nx;
      skip_cnt_p0 <= skip_nx;
      drdy_p0     <= drdy;
    end
  end

  // Free-running shifters; the FSM only decides when their contents form a frame.
  always_ff @(posedge sclk) begin
    for (int i = 0; i < int'(NCH); i++) sr_p0[i] <= {sr_p0[i][DW-2:0], dout[i]};
  end

  always_comb begin
    frame = '0;
    for (int i = 0; i < int'(NCH); i++) frame[i*DW +: DW] = sr_p0[i];
  end

  assign pop  = m.m_valid && m.m_ready;
  assign drop = push && full && !pop;

  always_ff @(posedge sclk) begin
    if (!areset_n) begin
      frame_err_cnt <= '0;
      drop_cnt      <= '0;
    end else begin
      if (trunc) frame_err_cnt <= CW'(sat_inc(32'(frame_err_cnt), CW));
      if (drop)  drop_cnt      <= CW'(sat_inc(32'(drop_cnt), CW));
    end
  end

  ads_rx_fifo #(
    .W     (NCH * DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .sclk     (sclk),
    .areset_n (areset_n),
    .push     (push),
    .wr_data  (frame),
    .pop      (pop),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  assign m.m_data  = head;
  assign m.m_valid = !empty;

endmodule

// File: tb/tb_ads_multi_rx.sv
// Directed bench for ads_multi_rx with DW=24, NCH=2, DEPTH=8; a SKIP=1 and a SKIP=0 instance share the pins.
module tb_ads_multi_rx;
  import ads_rx_pkg::*;

  logic        sclk;
  logic        areset_n;
  logic        en;
  logic        drdy;
  logic [1:0]  dout;
  logic        m_ready;
  logic [3:0]  level1, level0;
  logic [15:0] err1, drop1, err0, drop0;
  logic [47:0] q1[$];
  logic [47:0] q0[$];
  int          n_chk;
  int          n_pass;

  ads_rx_if #(.DW(24), .NCH(2)) bus1 ();
  ads_rx_if #(.DW(24), .NCH(2)) bus0 ();
  assign bus1.m_ready = m_ready;
  assign bus0.m_ready = m_ready;

  ads_multi_rx #(.DW(24), .NCH(2), .DEPTH(8), .SKIP(1), .CW(16)) dut (
    .sclk(sclk), .areset_n(areset_n), .en(en), .drdy(drdy), .dout(dout),
    .m(bus1), .level(level1), .frame_err_cnt(err1), .drop_cnt(drop1)
  );

  ads_multi_rx #(.DW(24), .NCH(2), .DEPTH(8), .SKIP(0), .CW(16)) dut_noskip (
    .sclk(sclk), .areset_n(areset_n), .en(en), .drdy(drdy), .dout(dout),
    .m(bus0), .level(level0), .frame_err_cnt(err0), .drop_cnt(drop0)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Record every accepted word, sampled mid-low-phase.
  always @(negedge sclk) begin
    #2;
    if (bus1.m_valid && bus1.m_ready) q1.push_back(bus1.m_data);
    if (bus0.m_valid && bus0.m_ready) q0.push_back(bus0.m_data);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  function automatic logic [47:0] pack2(input lane_word_t l0, input lane_word_t l1);
    return {l1[23:0], l0[23:0]};
  endfunction

  function automatic logic [23:0] pat(input int i);
    return 24'((i + 1) * 32'h111111);
  endfunction

  task automatic send_frame(input logic [23:0] w0, input logic [23:0] w1, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      @(negedge sclk);
      drdy = (k == 0);
      dout = {w1[23-k], w0[23-k]};
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge sclk);
      drdy = 1'b0;
      dout = 2'b00;
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    areset_n = 1'b0; en = 1'b1; drdy = 1'b1; dout = 2'b00; m_ready = 1'b1;

    // Reset with drdy held high
    repeat (3) @(negedge sclk);
    #2;
    chk("rst_valid", bus1.m_valid, 0);
    chk("rst_data",  bus1.m_data, 0);
    chk("rst_level", level1, 0);
    chk("rst_err",   err1, 0);
    chk("rst_drop",  drop1, 0);
    @(negedge sclk);
    areset_n = 1'b1;
    repeat (3) @(negedge sclk);
    idle(2);

    // Lock frame skipped, then latency of the first real frame
    q1.delete(); q0.delete();
    send_frame(24'h800001, 24'h7FFFFF, 24);
    idle(4);
    send_frame(24'h123456, 24'hABCDEF, 24);
    @(negedge sclk); drdy = 1'b0; dout = 2'b00;
    #2 chk("lat_before", bus1.m_valid, 0);
    @(negedge sclk);
    #2 chk("lat_valid", bus1.m_valid, 1);
    chk("lat_data", bus1.m_data, 48'hABCDEF_123456);
    idle(6);
    chk("skip_count", q1.size(), 1);
    chk("skip_word", (q1.size() > 0) ? q1[0] : {48{1'bx}}, 48'hABCDEF_123456);
    chk("noskip_count", q0.size(), 2);
    chk("noskip_first", (q0.size() > 0) ? q0[0] : {48{1'bx}}, 48'h7FFFFF_800001);
    chk("skip_err", err1, 0);

    // Ten back-to-back frames at the minimum period
    q1.delete(); q0.delete();
    for (int i = 0; i < 10; i++) send_frame(pat(i), ~pat(i), 24);
    idle(30);
    chk("b2b_count", q1.size(), 10);
    chk("b2b_count_noskip", q0.size(), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("b2b_word%0d", i), (q1.size() > i) ? q1[i] : {48{1'bx}}, {~pat(i), pat(i)});
    chk("b2b_err", err1, 0);
    chk("b2b_err_noskip", err0, 0);
    chk("b2b_level", level1, 0);

    // Truncated frame followed by a full one
    q1.delete(); q0.delete();
    send_frame(24'hFFFFFF, 24'h000000, 10);
    send_frame(24'h0F0F0F, 24'hF0F0F0, 24);
    idle(30);
    chk("trunc_err", err1, 1);
    chk("trunc_err_noskip", err0, 1);
    chk("trunc_count", q1.size(), 1);
    chk("trunc_word", (q1.size() > 0) ? q1[0] : {48{1'bx}}, 48'hF0F0F0_0F0F0F);

    // Overflow: ten frames into an eight-entry FIFO with no consumer
    q1.delete(); q0.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) send_frame(24'hA00000 + 24'(i), 24'h500000 + 24'(i), 24);
    idle(30);
    chk("full_level", level1, 8);
    chk("full_drop", drop1, 2);
    chk("full_head", bus1.m_data, 48'h500000_A00000);

    // Push into a full FIFO on the same edge as a pop
    send_frame(24'hA0000A, 24'h50000A, 24);
    @(negedge sclk); drdy = 1'b0; dout = 2'b00; m_ready = 1'b1;
    @(negedge sclk); m_ready = 1'b0;
    #2 chk("pushpop_level", level1, 8);
    chk("pushpop_drop", drop1, 2);
    chk("pushpop_popped", q1.size(), 1);
    m_ready = 1'b1;
    idle(20);
    chk("drain_count", q1.size(), 9);
    for (int j = 0; j < 8; j++)
      chk($sformatf("drain_word%0d", j), (q1.size() > j) ? q1[j] : {48{1'bx}},
          {24'h500000 + 24'(j), 24'hA00000 + 24'(j)});
    chk("drain_last", (q1.size() > 8) ? q1[8] : {48{1'bx}}, 48'h50000A_A0000A);
    chk("drain_level", level1, 0);

    // Enable dropped mid-frame, then re-enabled
    q1.delete(); q0.delete();
    send_frame(24'h111111, 24'h222222, 12);
    @(negedge sclk); en = 1'b0; drdy = 1'b0; dout = 2'b00;
    idle(5);
    en = 1'b1;
    idle(3);
    send_frame(24'hC0C0C0, 24'h0C0C0C, 24);
    send_frame(24'hD1D2D3, 24'h3D2D1D, 24);
    idle(30);
    chk("en_err", err1, 1);
    chk("en_count", q1.size(), 1);
    chk("en_word", (q1.size() > 0) ? q1[0] : {48{1'bx}}, 48'h3D2D1D_D1D2D3);
    chk("en_count_noskip", q0.size(), 2);

    // Reset in the middle of a frame with data buffered
    m_ready = 1'b0;
    send_frame(24'h654321, 24'h123456, 24);
    idle(2);
    chk("pre_rst_level", level1, 1);
    send_frame(24'h777777, 24'h888888, 10);
    @(negedge sclk); areset_n = 1'b0; drdy = 1'b0; dout = 2'b00;
    @(negedge sclk);
    #2;
    chk("mid_rst_valid", bus1.m_valid, 0);
    chk("mid_rst_data",  bus1.m_data, 0);
    chk("mid_rst_level", level1, 0);
    chk("mid_rst_err",   err1, 0);
    chk("mid_rst_drop",  drop1, 0);
    areset_n = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
